// File: rtl/dma_scheduler.sv
// VIC-II bus access scheduler: picks the memory access for every phi half-cycle,
// drives BA/AEC toward the CPU and keeps the DRAM refresh counter.
module dma_scheduler #(
  parameter int CYCLES_PER_LINE = 63
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       clk_phi,
  input  logic       phi_phase_start_1,
  input  logic [6:0] cycle_num,
  input  logic [8:0] raster_line,
  input  logic       badline,
  input  logic       idle,
  input  logic [7:0] sprite_dma_req,
  output logic       ba,
  output logic       aec,
  output logic [2:0] access_type,
  output logic [2:0] sprite_idx,
  output logic [7:0] refc
);

  typedef enum logic [2:0] {
    ACC_IDLE     = 3'd0,
    ACC_REFRESH  = 3'd1,
    ACC_CHAR     = 3'd2,
    ACC_GFX      = 3'd3,
    ACC_SPR_PTR  = 3'd4,
    ACC_SPR_DATA = 3'd5,
    ACC_GFX_IDLE = 3'd6
  } access_e;

  access_e    access_q;
  access_e    at_d;
  logic [2:0] idx_d;
  logic       ba_d;
  logic       aec_d;
  logic [7:0] spr_active;
  logic [7:0] spr_eff;
  logic       latch_strobe;

  assign access_type  = access_q;
  assign latch_strobe = (cycle_num == 7'd55) && !clk_phi;

  // The cycle-55 decision already sees the requests being latched in that strobe.
  assign spr_eff = latch_strobe ? sprite_dma_req : spr_active;

  always_comb begin
    int c;
    int f;
    int fn;
    int ws;
    int d;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    c     = int'(cycle_num);
    f     = 0;
    fn    = 0;
    ws    = 0;
    d     = 0;
    at_d  = ACC_IDLE;
    idx_d = 3'd0;
    ba_d  = 1'b1;

    if (badline && c >= 12 && c <= 54) ba_d = 1'b0;

    if (!clk_phi) begin
      if (c >= 10 && c <= 14)      at_d = ACC_REFRESH;
      else if (c >= 15 && c <= 54) at_d = idle ? ACC_GFX_IDLE : ACC_GFX;
    end else if (badline && c >= 15 && c <= 54) begin
      at_d = ACC_CHAR;
    end

    // Sprite slots are applied last so an active sprite 7 owns cycle 10 over refresh.
    for (int n = 0; n < 8; n++) begin
      f  = (58 + 2 * n) % CYCLES_PER_LINE;
      fn = (f + 1) % CYCLES_PER_LINE;
      ws = f - 3;
      if (ws < 0) ws = ws + CYCLES_PER_LINE;
      d = c - ws;
      if (d < 0) d = d + CYCLES_PER_LINE;
      if (spr_eff[n] && d <= 4) ba_d = 1'b0;
      if (c == f && !clk_phi) begin
        at_d  = ACC_SPR_PTR;
        idx_d = 3'(n);
      end else if (spr_eff[n] && (c == f || c == fn)) begin
        at_d  = ACC_SPR_DATA;
        idx_d = 3'(n);
      end
    end

    aec_d = clk_phi && !(at_d == ACC_CHAR || at_d == ACC_SPR_DATA);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      access_q   <= ACC_IDLE;
      sprite_idx <= 3'd0;
      ba         <= 1'b1;
      aec        <= 1'b1;
      refc       <= 8'hFF;
      spr_active <= 8'h00;
    end else if (phi_phase_start_1) begin
      access_q   <= at_d;
      sprite_idx <= idx_d;
      ba         <= ba_d;
      aec        <= aec_d;
      if (latch_strobe) spr_active <= sprite_dma_req;
      // refc steps at the strobe ending a refresh half, so the access itself uses the old value.
      if (!clk_phi && cycle_num == 7'd0 && raster_line == 9'd0) refc <= 8'hFF;
      else if (access_q == ACC_REFRESH)                          refc <= refc - 8'd1;
    end
  end

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler: drives phi half-cycles by hand and checks
// each scenario against hand-derived access sequences.
module tb_dma_scheduler;

  localparam logic [2:0] A_IDLE  = 3'd0;
  localparam logic [2:0] A_REF   = 3'd1;
  localparam logic [2:0] A_CHAR  = 3'd2;
  localparam logic [2:0] A_GFX   = 3'd3;
  localparam logic [2:0] A_PTR   = 3'd4;
  localparam logic [2:0] A_DATA  = 3'd5;
  localparam logic [2:0] A_GIDLE = 3'd6;

  typedef struct packed {
    logic [2:0] at;
    logic [2:0] idx;
    logic       ba;
    logic       aec;
    logic [7:0] rc;
  } obs_t;

  logic       clk_dot4x = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_phi = 1'b0;
  logic       phi_phase_start_1 = 1'b0;
  logic [6:0] cycle_num = 7'd0;
  logic [8:0] raster_line = 9'd5;
  logic       badline = 1'b0;
  logic       idle = 1'b0;
  logic [7:0] sprite_dma_req = 8'h00;
  logic       ba;
  logic       aec;
  logic [2:0] access_type;
  logic [2:0] sprite_idx;
  logic [7:0] refc;

  int   assertions = 0;
  int   failures = 0;
  obs_t cur [126];
  obs_t prv [126];
  logic [7:0] cur_req = 8'h00;
  int   bl_half = 999;
  logic idle_v = 1'b1;

  dma_scheduler #(.CYCLES_PER_LINE(63)) dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .clk_phi(clk_phi),
    .phi_phase_start_1(phi_phase_start_1), .cycle_num(cycle_num),
    .raster_line(raster_line), .badline(badline), .idle(idle),
    .sprite_dma_req(sprite_dma_req), .ba(ba), .aec(aec),
    .access_type(access_type), .sprite_idx(sprite_idx), .refc(refc)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  function automatic int ptr_slot(input int c);
    case (c)
      58: return 0;  60: return 1;  62: return 2;  1: return 3;
      3:  return 4;  5:  return 5;  7:  return 6;  9: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic do_half(input int c, input int ph);
    @(negedge clk_dot4x);
    cycle_num         = 7'(c);
    clk_phi           = ph[0];
    badline           = (c * 2 + ph >= bl_half);
    sprite_dma_req    = cur_req;
    idle              = idle_v;
    phi_phase_start_1 = 1'b1;
    @(negedge clk_dot4x);
    phi_phase_start_1 = 1'b0;
    cur[c*2+ph] = '{at: access_type, idx: sprite_idx, ba: ba, aec: aec, rc: refc};
  endtask

  task automatic run_range(input int c0, input int c1);
    for (int c = c0; c <= c1; c++)
      for (int ph = 0; ph < 2; ph++) do_half(c, ph);
  endtask

  task automatic check_reset_values(input string tag);
    assertions++; if (ba !== 1'b1) begin failures++; $display("FAIL %s_ba got=%b exp=1", tag, ba); end
    assertions++; if (aec !== 1'b1) begin failures++; $display("FAIL %s_aec got=%b exp=1", tag, aec); end
    assertions++; if (access_type !== A_IDLE) begin failures++; $display("FAIL %s_at got=%0d exp=0", tag, access_type); end
    assertions++; if (sprite_idx !== 3'd0) begin failures++; $display("FAIL %s_idx got=%0d exp=0", tag, sprite_idx); end
    assertions++; if (refc !== 8'hFF) begin failures++; $display("FAIL %s_refc got=%h exp=ff", tag, refc); end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #20;
    check_reset_values("reset");
    @(negedge clk_dot4x);
    rst_n = 1'b1;
  endtask

  task automatic test_plain_line;
    obs_t o;
    logic [2:0] e_at;
    logic [2:0] e_idx;
    int sl;
    raster_line = 9'd5; cur_req = 8'h00; bl_half = 999; idle_v = 1'b1;
    run_range(0, 62);
    for (int c = 0; c < 63; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        o = cur[c*2+ph]; e_at = A_IDLE; e_idx = 3'd0; sl = ptr_slot(c);
        if (ph == 0) begin
          if (c >= 10 && c <= 14)      e_at = A_REF;
          else if (c >= 15 && c <= 54) e_at = A_GIDLE;
          else if (sl >= 0) begin e_at = A_PTR; e_idx = 3'(sl); end
        end
        assertions++;
        if ({o.at, o.idx} !== {e_at, e_idx}) begin
          failures++; $display("FAIL plain_at c=%0d ph=%0d got=%0d/%0d exp=%0d/%0d", c, ph, o.at, o.idx, e_at, e_idx);
        end
        assertions++;
        if (o.ba !== 1'b1) begin failures++; $display("FAIL plain_ba c=%0d ph=%0d got=%b exp=1", c, ph, o.ba); end
        assertions++;
        if (o.aec !== ph[0]) begin failures++; $display("FAIL plain_aec c=%0d ph=%0d got=%b exp=%0d", c, ph, o.aec, ph); end
        if (ph == 0 && c >= 10 && c <= 14) begin
          assertions++;
          if (o.rc !== 8'(255 - (c - 10))) begin
            failures++; $display("FAIL plain_refc c=%0d got=%h exp=%h", c, o.rc, 8'(255 - (c - 10)));
          end
        end
      end
    end
  endtask

  task automatic test_badline_line;
    obs_t o;
    int n_char;
    logic e_ba;
    n_char = 0;
    raster_line = 9'd0; bl_half = 0; idle_v = 1'b0; cur_req = 8'h00;
    run_range(0, 62);
    raster_line = 9'd5; bl_half = 999;
    for (int c = 0; c < 63; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        o = cur[c*2+ph];
        e_ba = !(c >= 12 && c <= 54);
        assertions++;
        if (o.ba !== e_ba) begin failures++; $display("FAIL bl_ba c=%0d ph=%0d got=%b exp=%b", c, ph, o.ba, e_ba); end
        if (ph == 1) begin
          if (o.at === A_CHAR) n_char++;
          assertions++;
          if (o.at !== ((c >= 15 && c <= 54) ? A_CHAR : A_IDLE)) begin
            failures++; $display("FAIL bl_char c=%0d got=%0d", c, o.at);
          end
          assertions++;
          if (o.aec !== !(c >= 15 && c <= 54)) begin failures++; $display("FAIL bl_aec c=%0d got=%b", c, o.aec); end
        end else if (c >= 15 && c <= 54) begin
          assertions++;
          if (o.at !== A_GFX) begin failures++; $display("FAIL bl_gfx c=%0d got=%0d exp=3", c, o.at); end
        end
      end
    end
    assertions++;
    if (n_char != 40) begin failures++; $display("FAIL bl_char_count got=%0d exp=40", n_char); end
    assertions++;
    if (cur[20].rc !== 8'hFF) begin failures++; $display("FAIL bl_refc_reload got=%h exp=ff", cur[20].rc); end
  endtask

  task automatic test_sprite0;
    logic e_ba;
    cur_req = 8'h01; idle_v = 1'b1;
    run_range(0, 62);
    for (int c = 50; c < 63; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        e_ba = !(c >= 55 && c <= 59);
        assertions++;
        if (cur[c*2+ph].ba !== e_ba) begin
          failures++; $display("FAIL spr0_ba c=%0d ph=%0d got=%b exp=%b", c, ph, cur[c*2+ph].ba, e_ba);
        end
      end
    end
    assertions++; if ({cur[116].at, cur[116].idx} !== {A_PTR, 3'd0}) begin failures++; $display("FAIL spr0_ptr got=%0d/%0d", cur[116].at, cur[116].idx); end
    for (int h = 117; h <= 119; h++) begin
      assertions++;
      if ({cur[h].at, cur[h].idx} !== {A_DATA, 3'd0}) begin failures++; $display("FAIL spr0_data h=%0d got=%0d/%0d exp=5/0", h, cur[h].at, cur[h].idx); end
    end
    assertions++; if (cur[117].aec !== 1'b0 || cur[119].aec !== 1'b0) begin failures++; $display("FAIL spr0_aec got=%b%b exp=00", cur[117].aec, cur[119].aec); end
    assertions++; if ({cur[120].at, cur[120].idx} !== {A_PTR, 3'd1}) begin failures++; $display("FAIL spr0_ptr1 got=%0d/%0d", cur[120].at, cur[120].idx); end
    assertions++; if (cur[121].at !== A_IDLE || cur[121].aec !== 1'b1) begin failures++; $display("FAIL spr0_60h got=%0d/%b", cur[121].at, cur[121].aec); end
    assertions++; if (cur[122].at !== A_IDLE) begin failures++; $display("FAIL spr0_61l got=%0d exp=0", cur[122].at); end
    cur_req = 8'h00;
    run_range(0, 12);
    for (int h = 0; h < 26; h++) begin
      assertions++;
      if (cur[h].ba !== 1'b1 || cur[h].at === A_DATA) begin failures++; $display("FAIL spr0_next h=%0d ba=%b at=%0d", h, cur[h].ba, cur[h].at); end
    end
  endtask

  task automatic test_all_sprites;
    obs_t o;
    int cy;
    int ph;
    logic [2:0] e_at;
    cur_req = 8'hFF;
    run_range(13, 62);
    prv = cur;
    run_range(0, 12);
    for (int h = 110; h < 126; h++) begin
      assertions++;
      if (prv[h].ba !== 1'b0) begin failures++; $display("FAIL all_ba_pre h=%0d got=%b exp=0", h, prv[h].ba); end
    end
    for (int h = 0; h < 22; h++) begin
      assertions++;
      if (cur[h].ba !== 1'b0) begin failures++; $display("FAIL all_ba_post h=%0d got=%b exp=0", h, cur[h].ba); end
    end
    assertions++; if (cur[22].ba !== 1'b1) begin failures++; $display("FAIL all_ba_11 got=%b exp=1", cur[22].ba); end
    assertions++; if (cur[22].at !== A_REF) begin failures++; $display("FAIL all_ref_11 got=%0d exp=1", cur[22].at); end
    for (int h = 0; h < 32; h++) begin
      cy = (58 + h / 2) % 63; ph = h % 2;
      o = (cy >= 55) ? prv[cy*2+ph] : cur[cy*2+ph];
      e_at = (h % 4 == 0) ? A_PTR : A_DATA;
      assertions++;
      if ({o.at, o.idx} !== {e_at, 3'(h / 4)}) begin
        failures++; $display("FAIL all_seq c=%0d ph=%0d got=%0d/%0d exp=%0d/%0d", cy, ph, o.at, o.idx, e_at, h / 4);
      end
      if (ph == 1) begin
        assertions++;
        if (o.aec !== 1'b0) begin failures++; $display("FAIL all_aec c=%0d got=%b exp=0", cy, o.aec); end
      end
    end
  endtask

  task automatic test_badline_mid;
    logic e_ba;
    int h;
    cur_req = 8'h00; bl_half = 61; idle_v = 1'b0;
    run_range(13, 62);
    bl_half = 999;
    for (int c = 15; c <= 54; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        h = c * 2 + ph;
        e_ba = !(h >= 61);
        assertions++;
        if (cur[h].ba !== e_ba) begin failures++; $display("FAIL mid_ba c=%0d ph=%0d got=%b exp=%b", c, ph, cur[h].ba, e_ba); end
        if (ph == 1) begin
          assertions++;
          if (cur[h].at !== ((c >= 30) ? A_CHAR : A_IDLE)) begin failures++; $display("FAIL mid_char c=%0d got=%0d", c, cur[h].at); end
          assertions++;
          if (cur[h].aec !== (c < 30)) begin failures++; $display("FAIL mid_aec c=%0d got=%b", c, cur[h].aec); end
        end
      end
    end
  endtask

  task automatic test_hold_between_strobes;
    bl_half = 999; idle_v = 1'b1;
    do_half(20, 1);
    badline = 1'b1;
    repeat (3) @(negedge clk_dot4x);
    assertions++;
    if (access_type !== A_IDLE || ba !== 1'b1 || aec !== 1'b1) begin
      failures++; $display("FAIL hold_no_strobe got at=%0d ba=%b aec=%b exp 0/1/1", access_type, ba, aec);
    end
    bl_half = 0;
    do_half(21, 0);
    bl_half = 999;
    assertions++;
    if (cur[42].ba !== 1'b0 || cur[42].at !== A_GIDLE) begin
      failures++; $display("FAIL hold_next_strobe got ba=%b at=%0d exp 0/6", cur[42].ba, cur[42].at);
    end
  endtask

  task automatic test_reset_mid;
    raster_line = 9'd5; cur_req = 8'hFF; idle_v = 1'b1;
    run_range(0, 56);
    do_half(57, 0);
    assertions++; if (cur[114].ba !== 1'b0) begin failures++; $display("FAIL rmid_pre_ba got=%b exp=0", cur[114].ba); end
    rst_n = 1'b0;
    #1;
    check_reset_values("rmid_async");
    repeat (4) @(negedge clk_dot4x);
    rst_n = 1'b1;
    cur_req = 8'h00;
    run_range(20, 62);
    prv = cur;
    run_range(0, 14);
    for (int h = 40; h < 126; h++) begin
      assertions++;
      if (prv[h].at === A_DATA || prv[h].ba !== 1'b1) begin failures++; $display("FAIL rmid_after h=%0d at=%0d ba=%b", h, prv[h].at, prv[h].ba); end
    end
    for (int h = 0; h < 20; h++) begin
      assertions++;
      if (cur[h].at === A_DATA || cur[h].ba !== 1'b1) begin failures++; $display("FAIL rmid_wrap h=%0d at=%0d ba=%b", h, cur[h].at, cur[h].ba); end
    end
    for (int c = 10; c <= 14; c++) begin
      assertions++;
      if (cur[c*2].at !== A_REF || cur[c*2].rc !== 8'(255 - (c - 10))) begin
        failures++; $display("FAIL rmid_refc c=%0d got=%0d/%h exp=1/%h", c, cur[c*2].at, cur[c*2].rc, 8'(255 - (c - 10)));
      end
    end
    cur_req = 8'hFF;
    run_range(15, 58);
    do_half(59, 0);
    assertions++; if ({cur[118].at, cur[118].idx} !== {A_DATA, 3'd0}) begin failures++; $display("FAIL rmid2_pre got=%0d/%0d exp=5/0", cur[118].at, cur[118].idx); end
    rst_n = 1'b0;
    @(negedge clk_dot4x);
    rst_n = 1'b1;
    run_range(60, 62);
    prv = cur;
    run_range(0, 10);
    assertions++; if ({prv[120].at, prv[120].idx} !== {A_PTR, 3'd1}) begin failures++; $display("FAIL rmid2_ptr got=%0d/%0d exp=4/1", prv[120].at, prv[120].idx); end
    for (int h = 120; h < 126; h++) begin
      assertions++;
      if (prv[h].at === A_DATA || prv[h].ba !== 1'b1) begin failures++; $display("FAIL rmid2_pre_wrap h=%0d at=%0d ba=%b", h, prv[h].at, prv[h].ba); end
    end
    for (int h = 0; h < 22; h++) begin
      assertions++;
      if (cur[h].at === A_DATA || cur[h].ba !== 1'b1) begin failures++; $display("FAIL rmid2_post_wrap h=%0d at=%0d ba=%b", h, cur[h].at, cur[h].ba); end
    end
  endtask

  initial begin
    test_reset;
    test_plain_line;
    test_badline_line;
    test_sprite0;
    test_all_sprites;
    test_badline_mid;
    test_hold_between_strobes;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
